// File: rtl/prbs_pkg.sv
// Shared PRBS-7 definitions used by both the generator and the checker.
//   PRBS_WIDTH : word width (full LFSR state is carried in each word)
//   state_e    : checker FSM states
//   prbs_next  : successor function, polynomial x^7 + x^6 + 1 (period 127)
package prbs_pkg;

  localparam int unsigned PRBS_WIDTH = 7;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  // Shift left, feed back s[6]^s[5] into bit 0. All-zero is the lock-up state.
  function automatic logic [PRBS_WIDTH-1:0] prbs_next(input logic [PRBS_WIDTH-1:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Hex digit to seven-segment decoder (common-anode, segments active low).
//   hex : 4-bit value to display
//   seg : segment drives {g, f, e, d, c, b, a}, 0 = segment lit
module hex_to_seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/prbs7_err_counter.sv
// Saturating 8-bit error counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : zero the count; takes priority over inc
//   inc   : count one error (holds at 8'hFF)
//   count : current error count
module prbs7_err_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'h00;
    end else if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs7_checker.sv
// PRBS-7 receive checker. Self-synchronises by seeding a local LFSR from a received word,
// confirms LOCK_COUNT consecutive predicted words, then free-runs (flywheel) and flags
// every mismatching word. Errors are counted (saturating) and shown on two hex displays.
//   i_clk, i_rst   : clock and synchronous active-high reset
//   i_valid        : i_data holds a word this cycle
//   i_data         : received 7-bit PRBS word
//   i_clearErrors  : synchronous clear of the error count
//   o_locked       : high while locked
//   o_error        : one-cycle pulse on a mismatch while locked
//   o_errCount     : saturating error count
//   o_SEG0/o_SEG1  : low/high nibble of o_errCount, seven-segment encoded
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [PRBS_WIDTH-1:0] i_data,
  input  logic                  i_clearErrors,
  output logic                  o_locked,
  output logic                  o_error,
  output logic [7:0]            o_errCount,
  output logic [6:0]            o_SEG0,
  output logic [6:0]            o_SEG1
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  state_e                state_q, state_d;
  logic [PRBS_WIDTH-1:0] expected_q, expected_d;
  logic [3:0]            match_cnt_q, match_cnt_d;
  logic [3:0]            miss_cnt_q, miss_cnt_d;
  logic                  locked_q, locked_d;
  logic                  error_q, error_d;
  logic                  mismatch;
  logic                  data_zero;
  logic                  err_hit;

  assign mismatch  = (i_data != expected_q);
  assign data_zero = (i_data == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StSearch;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  // Next-state and prediction datapath
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (i_valid) begin
      case (state_q)
        StSearch: begin
          if (!data_zero) begin
            expected_d  = prbs_next(i_data);
            match_cnt_d = '0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (!mismatch) begin
            expected_d  = prbs_next(i_data);
            match_cnt_d = match_cnt_q + 4'd1;
            if ((match_cnt_q + 4'd1) == LockCnt) begin
              state_d    = StLocked;
              miss_cnt_d = '0;
            end
          end else if (!data_zero) begin
            // A wrong but legal word is a better guess than the old seed.
            expected_d  = prbs_next(i_data);
            match_cnt_d = '0;
          end else begin
            state_d = StSearch;
          end
        end
        StLocked: begin
          // Flywheel: never reseed from the line once locked.
          expected_d = prbs_next(expected_q);
          if (mismatch) begin
            miss_cnt_d = miss_cnt_q + 4'd1;
            if ((miss_cnt_q + 4'd1) == LossCnt) begin
              state_d = StSearch;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Output decode (registered in the state register process)
  always_comb begin
    err_hit  = i_valid && (state_q == StLocked) && mismatch;
    error_d  = err_hit;
    locked_d = (state_d == StLocked);
  end

  prbs7_err_counter u_err_counter (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_clearErrors),
    .inc   (err_hit),
    .count (o_errCount)
  );

  hex_to_seven_seg u_seg0 (
    .hex (o_errCount[3:0]),
    .seg (o_SEG0)
  );

  hex_to_seven_seg u_seg1 (
    .hex (o_errCount[7:4]),
    .seg (o_SEG1)
  );

  assign o_locked = locked_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_prbs7_checker.sv
module tb_prbs7_checker;

  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg1 = 7'h79;
  localparam logic [6:0] Seg4 = 7'h19;
  localparam logic [6:0] SegF = 7'h0E;

  logic       i_clk;
  logic       i_rst;
  logic       i_valid;
  logic [6:0] i_data;
  logic       i_clearErrors;
  logic       o_locked;
  logic       o_error;
  logic [7:0] o_errCount;
  logic [6:0] o_SEG0;
  logic [6:0] o_SEG1;

  int checks;
  int failures;

  prbs7_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .i_clearErrors (i_clearErrors),
    .o_locked      (o_locked),
    .o_error       (o_error),
    .o_errCount    (o_errCount),
    .o_SEG0        (o_SEG0),
    .o_SEG1        (o_SEG1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [6:0] model_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // One clock: apply inputs, let the edge sample them, settle 1 time unit past the edge.
  task automatic drive(input logic v, input logic [6:0] d, input logic clr);
    i_valid       = v;
    i_data        = d;
    i_clearErrors = clr;
    @(posedge i_clk);
    #1;
    i_valid       = 1'b0;
    i_clearErrors = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(1'b1, 7'h01, 1'b0);
    i_rst = 1'b0;
  endtask

  task automatic lock_from_01();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    drive(1'b1, 7'h04, 1'b0);
    drive(1'b1, 7'h08, 1'b0);
    drive(1'b1, 7'h10, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    do_reset();
    checks++;
    if (o_locked !== 1'b0) begin
      failures++; $display("FAIL reset_locked: got %b expected 0", o_locked);
    end
    checks++;
    if (o_error !== 1'b0) begin
      failures++; $display("FAIL reset_error: got %b expected 0", o_error);
    end
    checks++;
    if (o_errCount !== 8'h00) begin
      failures++; $display("FAIL reset_count: got %h expected 00", o_errCount);
    end
    checks++;
    if (o_SEG0 !== Seg0 || o_SEG1 !== Seg0) begin
      failures++;
      $display("FAIL reset_seg: got %h/%h expected %h/%h", o_SEG1, o_SEG0, Seg0, Seg0);
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    drive(1'b1, 7'h04, 1'b0);
    drive(1'b1, 7'h08, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++; $display("FAIL lock_early: got %b expected 0", o_locked);
    end
    drive(1'b1, 7'h10, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL lock_rise: got %b expected 1", o_locked);
    end
    checks++;
    if (o_errCount !== 8'h00 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL lock_clean: got count %h error %b expected 00 0", o_errCount, o_error);
    end
  endtask

  // Continues from the locked state left by test_lock (expected word 20).
  task automatic test_single_error();
    drive(1'b1, 7'h00, 1'b0);
    checks++;
    if (o_error !== 1'b1 || o_errCount !== 8'h01) begin
      failures++;
      $display("FAIL single_err_pulse: got error %b count %h expected 1 01", o_error, o_errCount);
    end
    drive(1'b1, 7'h41, 1'b0);
    checks++;
    if (o_error !== 1'b0 || o_errCount !== 8'h01) begin
      failures++;
      $display("FAIL single_err_after: got error %b count %h expected 0 01", o_error, o_errCount);
    end
    drive(1'b1, 7'h03, 1'b0);
    checks++;
    if (o_SEG0 !== Seg1 || o_SEG1 !== Seg0) begin
      failures++;
      $display("FAIL single_err_seg: got %h/%h expected %h/%h", o_SEG1, o_SEG0, Seg0, Seg1);
    end
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL single_err_locked: got %b expected 1", o_locked);
    end
  endtask

  // Idle cycles while locked must freeze everything, including the flywheel.
  task automatic test_valid_gaps_locked();
    for (int i = 0; i < 3; i++) drive(1'b0, 7'h00, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_error !== 1'b0 || o_errCount !== 8'h01) begin
      failures++;
      $display("FAIL gap_idle: got locked %b error %b count %h expected 1 0 01",
               o_locked, o_error, o_errCount);
    end
    drive(1'b1, 7'h06, 1'b0);
    checks++;
    if (o_error !== 1'b0) begin
      failures++; $display("FAIL gap_no_advance: got error %b expected 0", o_error);
    end
    drive(1'b0, 7'h0C, 1'b0);
    drive(1'b1, 7'h00, 1'b0);
    checks++;
    if (o_error !== 1'b1 || o_errCount !== 8'h02) begin
      failures++;
      $display("FAIL gap_err: got error %b count %h expected 1 02", o_error, o_errCount);
    end
    drive(1'b0, 7'h00, 1'b0);
    checks++;
    if (o_error !== 1'b0 || o_errCount !== 8'h02) begin
      failures++;
      $display("FAIL gap_err_drop: got error %b count %h expected 0 02", o_error, o_errCount);
    end
    drive(1'b1, 7'h18, 1'b0);
    checks++;
    if (o_error !== 1'b0 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL gap_resume: got error %b locked %b expected 0 1", o_error, o_locked);
    end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    lock_from_01();
    for (int i = 0; i < 3; i++) drive(1'b1, 7'h00, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL loss_early: got %b expected 1", o_locked);
    end
    drive(1'b1, 7'h00, 1'b0);
    checks++;
    if (o_locked !== 1'b0 || o_errCount !== 8'h04) begin
      failures++;
      $display("FAIL loss_drop: got locked %b count %h expected 0 04", o_locked, o_errCount);
    end
    checks++;
    if (o_SEG0 !== Seg4 || o_SEG1 !== Seg0) begin
      failures++;
      $display("FAIL loss_seg: got %h/%h expected %h/%h", o_SEG1, o_SEG0, Seg0, Seg4);
    end
    drive(1'b1, 7'h00, 1'b0);
    drive(1'b1, 7'h33, 1'b0);
    checks++;
    if (o_error !== 1'b0 || o_errCount !== 8'h04) begin
      failures++;
      $display("FAIL loss_uncounted: got error %b count %h expected 0 04", o_error, o_errCount);
    end
    do_reset();
    lock_from_01();
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL loss_relock: got %b expected 1", o_locked);
    end
  endtask

  // 01 seeds, 02 matches, 55 reseeds; next(55)=2B, 2B->57->2F->5F.
  task automatic test_reseed_verify();
    do_reset();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    drive(1'b1, 7'h55, 1'b0);
    drive(1'b1, 7'h2B, 1'b0);
    drive(1'b1, 7'h57, 1'b0);
    drive(1'b1, 7'h2F, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++; $display("FAIL reseed_early: got %b expected 0", o_locked);
    end
    drive(1'b1, 7'h5F, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_errCount !== 8'h00) begin
      failures++;
      $display("FAIL reseed_lock: got locked %b count %h expected 1 00", o_locked, o_errCount);
    end
  endtask

  task automatic test_reset_mid_verify();
    do_reset();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    do_reset();
    drive(1'b1, 7'h04, 1'b0);
    drive(1'b1, 7'h08, 1'b0);
    drive(1'b1, 7'h10, 1'b0);
    drive(1'b1, 7'h20, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++; $display("FAIL rst_mid_early: got %b expected 0", o_locked);
    end
    drive(1'b1, 7'h41, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL rst_mid_lock: got %b expected 1", o_locked);
    end
  endtask

  task automatic test_valid_gaps_verify();
    do_reset();
    drive(1'b1, 7'h01, 1'b0);
    drive(1'b0, 7'h00, 1'b0);
    drive(1'b1, 7'h02, 1'b0);
    drive(1'b0, 7'h55, 1'b0);
    drive(1'b0, 7'h00, 1'b0);
    drive(1'b1, 7'h04, 1'b0);
    drive(1'b1, 7'h08, 1'b0);
    drive(1'b0, 7'h10, 1'b0);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++; $display("FAIL gap_verify_early: got %b expected 0", o_locked);
    end
    drive(1'b1, 7'h10, 1'b0);
    checks++;
    if (o_locked !== 1'b1) begin
      failures++; $display("FAIL gap_verify_lock: got %b expected 1", o_locked);
    end
  endtask

  task automatic test_saturation_clear();
    logic [6:0] exp_word;
    do_reset();
    lock_from_01();
    exp_word = 7'h20;
    // Three errors then one good word keeps lock while piling up 300 errors.
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 3; j++) begin
        drive(1'b1, exp_word ^ 7'h01, 1'b0);
        exp_word = model_next(exp_word);
      end
      drive(1'b1, exp_word, 1'b0);
      exp_word = model_next(exp_word);
    end
    checks++;
    if (o_errCount !== 8'hFF || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL sat_count: got count %h locked %b expected FF 1", o_errCount, o_locked);
    end
    checks++;
    if (o_SEG0 !== SegF || o_SEG1 !== SegF) begin
      failures++;
      $display("FAIL sat_seg: got %h/%h expected %h/%h", o_SEG1, o_SEG0, SegF, SegF);
    end
    drive(1'b1, exp_word ^ 7'h01, 1'b1);
    exp_word = model_next(exp_word);
    checks++;
    if (o_errCount !== 8'h00 || o_error !== 1'b1) begin
      failures++;
      $display("FAIL clear_wins: got count %h error %b expected 00 1", o_errCount, o_error);
    end
    drive(1'b1, exp_word, 1'b0);
    checks++;
    if (o_errCount !== 8'h00 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL clear_hold: got count %h locked %b expected 00 1", o_errCount, o_locked);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    i_rst         = 1'b1;
    i_valid       = 1'b0;
    i_data        = 7'h00;
    i_clearErrors = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    test_reset();
    test_lock();
    test_single_error();
    test_valid_gaps_locked();
    test_loss_of_lock();
    test_reseed_verify();
    test_reset_mid_verify();
    test_valid_gaps_verify();
    test_saturation_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
